// File: rtl/ctr_drbg_ctrl.sv
// CTR-DRBG command sequencer: holds the working state (Key, V), runs the external
// 1-cycle update datapath and streams GENERATE output blocks over valid/ready.
module ctr_drbg_ctrl #(
  parameter logic [47:0] RESEED_INTERVAL = 48'd1000
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cmd_valid,
  output logic         cmd_ready,
  input  logic [1:0]   cmd_op,
  input  logic [383:0] cmd_seed,
  input  logic [7:0]   cmd_nblocks,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] out_data,
  output logic         out_last,
  output logic         done,
  output logic         err,
  output logic         instantiated,
  output logic [47:0]  reseed_cnt,
  output logic [255:0] upd_key,
  output logic [127:0] upd_V,
  output logic [383:0] upd_provided_data,
  input  logic [255:0] upd_new_key,
  input  logic [127:0] upd_new_V
);

  localparam logic [1:0] OP_INST   = 2'b00;
  localparam logic [1:0] OP_RESEED = 2'b01;
  localparam logic [1:0] OP_GEN    = 2'b10;

  typedef enum logic [2:0] {
    S_IDLE,
    S_UPD_ISSUE,
    S_UPD_WAIT,
    S_GEN_INC,
    S_GEN_OUT,
    S_DONE
  } state_t;

  state_t         state_q, state_d;
  logic [255:0]   key_q, key_d;
  logic [127:0]   v_q, v_d;
  logic [383:0]   seed_q, seed_d;
  logic [1:0]     op_q, op_d;
  logic [7:0]     nleft_q, nleft_d;
  logic           err_q, err_d;
  logic [47:0]    cnt_q, cnt_d;
  logic           inst_q, inst_d;
  logic           accept_err;

  assign accept_err = (cmd_op == 2'b11)
                   || ((cmd_op != OP_INST) && !inst_q)
                   || ((cmd_op == OP_GEN) && ((cmd_nblocks == 8'd0) || (cnt_q > RESEED_INTERVAL)));

  assign upd_key           = key_q;
  assign upd_V             = v_q;
  assign upd_provided_data = seed_q;
  assign out_data          = v_q ^ key_q[255:128] ^ key_q[127:0];
  assign instantiated      = inst_q;
  assign reseed_cnt        = cnt_q;

  always_comb begin
    state_d   = state_q;
    key_d     = key_q;
    v_d       = v_q;
    seed_d    = seed_q;
    op_d      = op_q;
    nleft_d   = nleft_q;
    err_d     = err_q;
    cnt_d     = cnt_q;
    inst_d    = inst_q;
    cmd_ready = 1'b0;
    out_valid = 1'b0;
    out_last  = 1'b0;
    done      = 1'b0;
    err       = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          op_d    = cmd_op;
          seed_d  = cmd_seed;
          nleft_d = cmd_nblocks;
          err_d   = accept_err;
          if (accept_err) begin
            state_d = S_DONE;
          end else if (cmd_op == OP_GEN) begin
            state_d = S_GEN_INC;
          end else begin
            // INSTANTIATE starts the update from an all-zero working state
            if (cmd_op == OP_INST) begin
              key_d = '0;
              v_d   = '0;
            end
            state_d = S_UPD_ISSUE;
          end
        end
      end
      S_UPD_ISSUE: state_d = S_UPD_WAIT;
      S_UPD_WAIT: begin
        key_d   = upd_new_key;
        v_d     = upd_new_V;
        state_d = S_DONE;
        if (op_q == OP_GEN) begin
          if (cnt_q != '1) cnt_d = cnt_q + 48'd1;
        end else begin
          cnt_d = 48'd1;
          if (op_q == OP_INST) inst_d = 1'b1;
        end
      end
      S_GEN_INC: begin
        v_d     = v_q + 128'd1;
        state_d = S_GEN_OUT;
      end
      S_GEN_OUT: begin
        out_valid = 1'b1;
        out_last  = (nleft_q == 8'd1);
        if (out_ready) begin
          if (nleft_q == 8'd1) begin
            state_d = S_UPD_ISSUE;
          end else begin
            nleft_d = nleft_q - 8'd1;
            state_d = S_GEN_INC;
          end
        end
      end
      S_DONE: begin
        done    = 1'b1;
        err     = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      key_q   <= '0;
      v_q     <= '0;
      seed_q  <= '0;
      op_q    <= OP_INST;
      nleft_q <= '0;
      err_q   <= 1'b0;
      cnt_q   <= '0;
      inst_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      key_q   <= key_d;
      v_q     <= v_d;
      seed_q  <= seed_d;
      op_q    <= op_d;
      nleft_q <= nleft_d;
      err_q   <= err_d;
      cnt_q   <= cnt_d;
      inst_q  <= inst_d;
    end
  end

endmodule
